// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl
//   Instruction-fetch stage controller. Owns the fetch PC, drives a
//   single-outstanding instruction-memory request/response handshake and
//   the IF/ID pipeline register. Follows the hazard unit's write enables
//   and the EX-stage redirect (taken branch / jump).
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   pc_write_en       0 = do not issue a new fetch this cycle
//   if_id_write_en    0 = IF/ID holds its contents
//   stall             hazard-unit stall, counted in stall_cycles
//   redirect_valid    squash in-flight work and refetch from redirect_pc
//   redirect_pc       redirect target
//   imem_req/addr     fetch request (accepted when imem_req && imem_ready)
//   imem_ready        memory can accept a request
//   imem_rvalid/rdata fetch response, at least one cycle after acceptance
//   pc                architectural fetch PC
//   if_id_valid/pc/instr  IF/ID pipeline register
//   stall_cycles      saturating count of stall cycles
module fetch_stage_ctrl #(
    parameter int unsigned             PC_WIDTH    = 32,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pc_write_en,
    input  logic                   if_id_write_en,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   if_id_valid,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [15:0]            stall_cycles
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_BUF} state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    state_t                 state;
    logic                   kill;        // outstanding response is stale, drop it
    logic [PC_WIDTH-1:0]    req_pc;      // address of the outstanding request
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;

    logic rsp_take;   // live (non-killed) response this cycle
    logic wait_open;  // in WAIT and the response has not come back yet

    assign rsp_take  = (state == S_WAIT) && imem_rvalid && !kill;
    assign wait_open = (state == S_WAIT) && !imem_rvalid;

    assign imem_req  = !reset && (state == S_FETCH) && pc_write_en && !redirect_valid;
    assign imem_addr = pc;

    // Fetch FSM and PC
    always_ff @(posedge clk) begin
        if (reset) begin
            // A request still in flight at reset must not land in IF/ID:
            // park in WAIT with kill set until its response drains.
            state      <= wait_open ? S_WAIT : S_FETCH;
            kill       <= wait_open;
            pc         <= RESET_PC;
            req_pc     <= '0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            // Outstanding request not yet answered: wait for it and drop it.
            // A same-cycle response is simply discarded.
            if (wait_open) begin
                state <= S_WAIT;
                kill  <= 1'b1;
            end else begin
                state <= S_FETCH;
                kill  <= 1'b0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_FETCH;
                        end else begin
                            pc <= req_pc + PC_STEP;
                            if (if_id_write_en) begin
                                state <= S_FETCH;
                            end else begin
                                skid_pc    <= req_pc;
                                skid_instr <= imem_rdata;
                                state      <= S_BUF;
                            end
                        end
                    end
                end
                S_BUF: begin
                    if (if_id_write_en) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            // Flush overrides the hold request.
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (if_id_write_en) begin
            if (rsp_take) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_instr <= imem_rdata;
            end else if (state == S_BUF) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_pc;
                if_id_instr <= skid_instr;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write_en = 1'b1;
    logic        if_id_write_en = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;

    always #5 clk = ~clk;

    fetch_stage_ctrl #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .stall_cycles(stall_cycles)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // Instruction memory: one outstanding request, latency 'lat' cycles,
    // not reset, so pre-reset requests still answer after reset.
    logic        m_pend = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = '0;

    always @(posedge clk) begin
        if (m_pend) begin
            if (m_cnt == 0) m_pend <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
        if (imem_req && imem_ready) begin
            m_pend <= 1'b1;
            m_cnt  <= lat - 1;
            m_addr <= imem_addr;
        end
    end

    assign imem_rvalid = m_pend && (m_cnt == 0);
    assign imem_rdata  = imem_rvalid ? mem_word(m_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;

        // reset state
        cyc; #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_valid", 32'(if_id_valid), 0);
        chk("rst_ifid_pc", if_id_pc, 0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_req", 32'(imem_req), 0);
        reset = 1'b0; #1;

        // sequential fetch with wrap: FFFFFFFC, 0, 4
        for (int k = 0; k < 3; k++) begin
            a = RST_PC + 32'(4 * k);
            chk("seq_req", 32'(imem_req), 1);
            chk("seq_addr", imem_addr, a);
            cyc; #1;
            chk("seq_wait_noreq", 32'(imem_req), 0);
            cyc; #1;
            chk("seq_valid", 32'(if_id_valid), 1);
            chk("seq_ifid_pc", if_id_pc, a);
            chk("seq_instr", if_id_instr, mem_word(a));
        end

        // IF/ID hold while the response for 8 returns -> skid buffer
        if_id_write_en = 1'b0; #1;
        chk("hold_req", 32'(imem_req), 1);
        chk("hold_addr", imem_addr, 32'h8);
        cyc; #1;
        chk("hold1_req", 32'(imem_req), 0);
        chk("hold1_ifid_pc", if_id_pc, 32'h4);
        chk("hold1_valid", 32'(if_id_valid), 1);
        cyc; #1;
        chk("hold2_req", 32'(imem_req), 0);
        chk("hold2_ifid_pc", if_id_pc, 32'h4);
        chk("hold2_pc", pc, 32'hC);
        cyc; if_id_write_en = 1'b1; #1;
        chk("hold3_req", 32'(imem_req), 0);
        chk("hold3_ifid_pc", if_id_pc, 32'h4);
        cyc; #1;
        chk("rel_ifid_pc", if_id_pc, 32'h8);
        chk("rel_valid", 32'(if_id_valid), 1);
        chk("rel_instr", if_id_instr, mem_word(32'h8));
        chk("rel_req", 32'(imem_req), 1);
        chk("rel_addr", imem_addr, 32'hC);
        lat = 3;

        // redirect while waiting on a 3-cycle response
        cyc; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        chk("rdw_req", 32'(imem_req), 0);
        cyc; redirect_valid = 1'b0; #1;
        chk("rdw_pc", pc, 32'h100);
        chk("rdw_valid", 32'(if_id_valid), 0);
        chk("rdw_instr", if_id_instr, NOP);
        chk("rdw_req", 32'(imem_req), 0);
        cyc; #1;
        chk("rdw_kill_req", 32'(imem_req), 0);
        cyc; #1;
        chk("rdw_new_req", 32'(imem_req), 1);
        chk("rdw_new_addr", imem_addr, 32'h100);
        chk("rdw_drop_valid", 32'(if_id_valid), 0);
        lat = 1;
        cyc;
        cyc; #1;
        chk("rdw_ifid_pc", if_id_pc, 32'h100);
        chk("rdw_ifid_valid", 32'(if_id_valid), 1);
        chk("rdw_ifid_instr", if_id_instr, mem_word(32'h100));
        chk("rdw_next_addr", imem_addr, 32'h104);

        // redirect coincident with response, IF/ID held
        cyc; if_id_write_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc; redirect_valid = 1'b0; if_id_write_en = 1'b1; #1;
        chk("rdr_valid", 32'(if_id_valid), 0);
        chk("rdr_instr", if_id_instr, NOP);
        chk("rdr_ifid_pc", if_id_pc, 32'h100);
        chk("rdr_pc", pc, 32'h200);
        chk("rdr_req", 32'(imem_req), 1);
        chk("rdr_addr", imem_addr, 32'h200);

        // pc_write_en=0 with stall for 5 cycles
        pc_write_en = 1'b0; stall = 1'b1; #1;
        chk("stl_req", 32'(imem_req), 0);
        for (int i = 0; i < 4; i++) begin
            cyc; #1;
            chk("stl_req", 32'(imem_req), 0);
            chk("stl_pc", pc, 32'h200);
        end
        cyc; pc_write_en = 1'b1; stall = 1'b0; #1;
        chk("stl_count", 32'(stall_cycles), 5);
        chk("stl_resume_req", 32'(imem_req), 1);
        chk("stl_resume_addr", imem_addr, 32'h200);
        lat = 3;

        // reset while waiting; the late response must be ignored
        cyc; reset = 1'b1; #1;
        chk("rw_req", 32'(imem_req), 0);
        cyc; reset = 1'b0; #1;
        chk("rw_pc", pc, RST_PC);
        chk("rw_valid", 32'(if_id_valid), 0);
        chk("rw_ifid_pc", if_id_pc, 0);
        chk("rw_stall", 32'(stall_cycles), 0);
        chk("rw_req_wait", 32'(imem_req), 0);
        cyc; #1;
        chk("rw_late_req", 32'(imem_req), 0);
        cyc; #1;
        chk("rw_late_valid", 32'(if_id_valid), 0);
        chk("rw_refetch_req", 32'(imem_req), 1);
        chk("rw_refetch_addr", imem_addr, RST_PC);
        lat = 1;
        cyc;
        cyc; #1;
        chk("rw_ifid_valid", 32'(if_id_valid), 1);
        chk("rw_ifid_pc2", if_id_pc, RST_PC);
        chk("rw_ifid_instr", if_id_instr, mem_word(RST_PC));
        chk("rw_wrap_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
